regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
- Read-side consumer of the datapath register file: on a start pulse, walks register indices 0..NUM_REGS-1 through one asynchronous read port.
- Emits each {index, value} pair on a valid/ready stream.
- Used by the debug/trace path to dump architectural state, e.g. after program completion, without probing the array directly.

Parameters:
- NUM_REGS, 32, number of registers scanned (power of two).
- IDX_W, 5, index width, equal to log2(NUM_REGS).
- DATA_W, 32, register data width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a dump; ignored unless IDLE
- rdAddr  output  IDX_W  read address to the register file read port
- rdData  input  DATA_W  combinational read data for rdAddr, same cycle
- outValid  output  1  outIndex/outData hold a valid entry
- outReady  input  1  downstream accepts the entry this cycle
- outIndex  output  IDX_W  register index of the current entry
- outData  output  DATA_W  register value of the current entry
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse after the last entry is accepted

Behaviour:
- Reset values: state IDLE, idx=0, rdAddr=0, outValid=0, outIndex=0, outData=0, busy=0, done=0. Reset wins over every other input, including mid-dump; a partial dump is abandoned without a done pulse.
- rdAddr is the registered idx and is valid in every state.
- FSM:
  - IDLE: start=1 -> idx<=0, go to FETCH.
  - FETCH: capture outData<=rdData and outIndex<=idx, go to SEND.
  - SEND: outValid=1. If outReady=1 (handshake): idx==NUM_REGS-1 -> DONE; otherwise idx<=idx+1 and go to FETCH. If outReady=0, hold.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Handshake:
  - outIndex/outData must remain stable while outValid=1 and outReady=0.
  - outValid must not drop without a handshake, except on reset.
  - outReady may be high before outValid; that is legal and transfers nothing.
- Latency:
  - start sampled at edge k -> outValid=1 from cycle k+2.
  - With outReady held high, there are 2 cycles per entry; a full dump is 2*NUM_REGS+2 cycles from start to done.
- Index arithmetic: idx is IDX_W bits and must never wrap; the terminal test is idx==NUM_REGS-1 before incrementing.
- No snapshot: register writes during a dump are visible for indices not yet fetched. Entry 0 reads whatever the file returns, which is 0 by construction.
- start while busy has no effect. start in the same cycle as the DONE state is ignored; a new dump requires start in IDLE.

Optional Feature:
- Macro REGDUMP_SKIP_ZERO_EN.
- Defined: in FETCH, an entry whose rdData==0 is not presented.
  - idx==NUM_REGS-1 -> DONE.
  - Otherwise idx<=idx+1 and stay in FETCH, giving one cycle per skipped entry.
  - An all-zero file still produces the done pulse with zero transfers.
- Undefined: every index 0..NUM_REGS-1 is emitted in order.

Decomposition:
- Shared package regdump_pkg holds:
  - the state enum (IDLE, FETCH, SEND, DONE);
  - localparams for the default NUM_REGS/IDX_W/DATA_W;
  - a packed struct {index, data} for the stream payload.
- No sub-module is needed: a single FSM plus idx counter.
- The bench instantiates the existing register file as the read target.

Test Plan:
- Register file preloaded x1=1, x29=252, all others 0; outReady=1; pulse start -> 32 entries in index order 0..31, entry 1 = 0x1, entry 29 = 0xFC, others 0; done pulses once, 66 cycles after the start edge.
- outReady held low for 5 cycles while outValid is high on entry 3 -> outIndex=3 and outData are stable for all 5 cycles; entry 4 appears only after the handshake.
- start pulsed again at entry 10 mid-dump -> ignored; the sequence continues at 11 with exactly 32 entries total.
- reset asserted while in SEND at entry 7 -> next cycle all outputs are 0, state is IDLE, no done pulse; a fresh start restarts at index 0.
- Register file write x5=0xDEAD while the dump is at index 2 -> entry 5 reports 0xDEAD.
- With REGDUMP_SKIP_ZERO_EN defined and the same preload -> exactly 2 entries ({1,0x1}, {29,0xFC}), then done; an all-zero file -> 0 entries and a single done pulse.

Source files
------------

// File: rtl/regdump_pkg.sv
// Shared types for the register-file dump reader: FSM state encoding,
// default geometry and the {index, data} stream payload.
package regdump_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int IDX_W_DEF    = 5;
  localparam int DATA_W_DEF   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [IDX_W_DEF-1:0]  index;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks register indices 0..NUM_REGS-1 through one async read port and streams
// {index, value} pairs. Define REGDUMP_SKIP_ZERO_EN to suppress zero-valued entries.
//
// state | meaning
// IDLE  | waiting for start; rdAddr parked at the last idx
// FETCH | rdData for idx is sampled into the output holding registers
// SEND  | entry presented with outValid; waits for outReady
// DONE  | one-cycle done pulse, then back to IDLE
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [IDX_W-1:0]  rdAddr,
  input  logic [DATA_W-1:0] rdData,
  output logic              outValid,
  input  logic              outReady,
  output logic [IDX_W-1:0]  outIndex,
  output logic [DATA_W-1:0] outData,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;

  assign rdAddr = idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      outValid <= 1'b0;
      outIndex <= '0;
      outData  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
`ifdef REGDUMP_SKIP_ZERO_EN
          // zero entries cost one FETCH cycle each and are never presented
          if (rdData == '0) begin
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            outData  <= rdData;
            outIndex <= idx;
            outValid <= 1'b1;
            state    <= SEND;
          end
`else
          outData  <= rdData;
          outIndex <= idx;
          outValid <= 1'b1;
          state    <= SEND;
`endif
        end
        SEND: begin
          if (outReady) begin
            outValid <= 1'b0;
            // terminal test before increment so idx never wraps
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader; honours REGDUMP_SKIP_ZERO_EN when
// building expected entries and cycle counts.
module tb_regfile_dump_reader;
  import regdump_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, outReady;
  logic        outValid, busy, done;
  logic [4:0]  rdAddr, outIndex;
  logic [31:0] rdData, outData;

  logic [31:0] regs     [32];
  logic [31:0] exp_regs [32];
  entry_t      sb_q[$];
  entry_t      mon_e;

  int n_tests   = 0;
  int n_fail    = 0;
  int n_entries = 0;
  int n_done    = 0;

  always #5 clk = ~clk;

  // bench-side register file: combinational read, x0 stays zero
  assign rdData = regs[rdAddr];

  regfile_dump_reader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rdAddr   (rdAddr),
    .rdData   (rdData),
    .outValid (outValid),
    .outReady (outReady),
    .outIndex (outIndex),
    .outData  (outData),
    .busy     (busy),
    .done     (done)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) n_done++;
    if (!reset && outValid && outReady) begin
      if (sb_q.size() == 0) begin
        check_val("sb_extra_entry", 64'(outIndex), 64'hFFFF);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("sb_index", 64'(outIndex), 64'(mon_e.index));
        check_val("sb_data", 64'(outData), 64'(mon_e.data));
      end
      n_entries++;
    end
  end

  task automatic load_file(input logic [31:0] v1, input logic [31:0] v29);
    for (int i = 0; i < 32; i++) begin
      regs[i]     = '0;
      exp_regs[i] = '0;
    end
    regs[1]  = v1;   exp_regs[1]  = v1;
    regs[29] = v29;  exp_regs[29] = v29;
  endtask

  // cost = cycles spent in FETCH/SEND with outReady held high
  task automatic push_expected(output int n, output int cost);
    entry_t t;
    n = 0;
    cost = 0;
    for (int i = 0; i < 32; i++) begin
`ifdef REGDUMP_SKIP_ZERO_EN
      if (exp_regs[i] == 32'd0) begin
        cost += 1;
        continue;
      end
`endif
      t.index = 5'(i);
      t.data  = exp_regs[i];
      sb_q.push_back(t);
      n++;
      cost += 2;
    end
  endtask

  // cycles counts inclusively from the cycle start is high to the cycle done is high
  task automatic run_dump(input int hold_at, input int restart_at, input int reset_at,
                          input int write_at, output int cycles, output int exp_cycles);
    int          exp_n, cost;
    bit          held, restarted, written;
    logic [31:0] hold_data;
    held = 0; restarted = 0; written = 0;
    cycles = 0;
    sb_q.delete();
    push_expected(exp_n, cost);
    exp_cycles = 2 + cost;
    n_entries = 0;
    n_done    = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    cycles = 2;
    while (!done && cycles < 400) begin
      if (write_at >= 0 && !written && rdAddr == 5'(write_at)) begin
        regs[5] = 32'hDEAD;
        written = 1;
      end
      if (restart_at >= 0 && !restarted && outValid && outIndex == 5'(restart_at)) begin
        start = 1'b1;
        restarted = 1;
      end
      if (hold_at >= 0 && !held && outValid && outIndex == 5'(hold_at)) begin
        held      = 1;
        hold_data = outData;
        outReady  = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          cycles++;
          check_val("hold_valid", 64'(outValid), 64'd1);
          check_val("hold_index", 64'(outIndex), 64'(hold_at));
          check_val("hold_data", 64'(outData), 64'(hold_data));
        end
        outReady = 1'b1;
      end
      if (reset_at >= 0 && outValid && outIndex == 5'(reset_at)) begin
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("rst_mid_valid", 64'(outValid), 64'd0);
        check_val("rst_mid_index", 64'(outIndex), 64'd0);
        check_val("rst_mid_data", 64'(outData), 64'd0);
        check_val("rst_mid_addr", 64'(rdAddr), 64'd0);
        check_val("rst_mid_busy", 64'(busy), 64'd0);
        check_val("rst_mid_state", 64'(dut.state), 64'(IDLE));
        check_val("rst_mid_no_done", 64'(n_done), 64'd0);
        reset = 1'b0;
        sb_q.delete();
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cycles++;
    end
    check_val("done_seen", 64'(done), 64'd1);
    @(posedge clk); #1;
    check_val("done_one_cycle", 64'(done), 64'd0);
    check_val("busy_after_done", 64'(busy), 64'd0);
    check_val("done_count", 64'(n_done), 64'd1);
    check_val("entry_count", 64'(n_entries), 64'(exp_n));
    check_val("sb_leftover", 64'(sb_q.size()), 64'd0);
  endtask

  int cyc, exp_cyc;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    outReady = 1'b0;
    load_file(32'h1, 32'hFC);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", 64'(outValid), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_addr", 64'(rdAddr), 64'd0);
    check_val("rst_index", 64'(outIndex), 64'd0);
    check_val("rst_data", 64'(outData), 64'd0);
    reset    = 1'b0;
    outReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("idle_ready_no_valid", 64'(outValid), 64'd0);

    // full dump, ready always high
    run_dump(-1, -1, -1, -1, cyc, exp_cyc);
    check_val("full_cycles", 64'(cyc), 64'(exp_cyc));

`ifndef REGDUMP_SKIP_ZERO_EN
    // backpressure at 3, restart attempt at 10, x5 written while at index 2
    load_file(32'h1, 32'hFC);
    exp_regs[5] = 32'hDEAD;
    run_dump(3, 10, -1, 2, cyc, exp_cyc);
    check_val("stall_cycles", 64'(cyc), 64'(exp_cyc + 5));

    // reset in SEND at entry 7, then a fresh dump from index 0
    load_file(32'h1, 32'hFC);
    run_dump(-1, -1, 7, -1, cyc, exp_cyc);
    repeat (2) @(posedge clk);
    #1;
    check_val("post_rst_idle_valid", 64'(outValid), 64'd0);
    run_dump(-1, -1, -1, -1, cyc, exp_cyc);
    check_val("restart_cycles", 64'(cyc), 64'(exp_cyc));
`else
    // all-zero file: no transfers, single done pulse
    load_file(32'h0, 32'h0);
    run_dump(-1, -1, -1, -1, cyc, exp_cyc);
    check_val("zero_file_cycles", 64'(cyc), 64'(exp_cyc));
    load_file(32'h1, 32'hFC);
    exp_regs[5] = 32'hDEAD;
    run_dump(-1, -1, -1, 2, cyc, exp_cyc);
    check_val("skip_write_cycles", 64'(cyc), 64'(exp_cyc));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
